cpu: RTL and testbench

CPU -- requirements
Module: cpu

---
 rtl/cpu.sv | 270 +++++++++++++++++++++++++++
 tb/tb_cpu.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/cpu.sv
// Single-cycle RV32I subset core (LW, SW, ADD, AND, OR, ADDI, BEQ, JAL, LUI, AUIPC)
// with an internal instruction ROM, a 32x32 register file and a word-addressed data RAM.
// Build option: define CPU_UPPER_IMM_EN to execute LUI/AUIPC; otherwise they retire as NOPs.

module cpu_regfile (
  input  logic        clk,
  input  logic        rst,
  input  logic        we,
  input  logic [4:0]  waddr,
  input  logic [31:0] wdata,
  input  logic [4:0]  raddr1,
  input  logic [4:0]  raddr2,
  output logic [31:0] rdata1_c,
  output logic [31:0] rdata2_c
);
  logic [31:0] registers [0:31];

  // Clear every register on reset; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) registers[i] <= '0;
    end else if (we && (waddr != 5'd0)) begin
      registers[waddr] <= wdata;
    end
  end

  assign rdata1_c = (raddr1 == 5'd0) ? 32'd0 : registers[raddr1];
  assign rdata2_c = (raddr2 == 5'd0) ? 32'd0 : registers[raddr2];
endmodule

module cpu_dmem #(
  parameter int unsigned DMEM_WORDS = 64
) (
  input  logic        clk,
  input  logic        we,
  input  logic [29:0] word_addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata_c
);
  localparam int unsigned DAW = (DMEM_WORDS > 1) ? $clog2(DMEM_WORDS) : 1;

  typedef logic [31:0] mem_t [0:DMEM_WORDS-1];

  // Power-up image of the data RAM; contents are deliberately not touched by reset.
  function automatic mem_t mem_init();
    mem_t m;
    for (int i = 0; i < int'(DMEM_WORDS); i++) begin
      case (i)
        0:       m[i] = 32'hAEAEAEAE;
        2:       m[i] = 32'hABCDEF11;
        3:       m[i] = 32'hABCDEF11;
        4:       m[i] = 32'hF2F2F2F2;
        5:       m[i] = 32'h12345678;
        6:       m[i] = 32'h125F552D;
        7:       m[i] = 32'h7F4FD46A;
        default: m[i] = 32'h00000000;
      endcase
    end
    return m;
  endfunction

  logic [31:0]    mem [0:DMEM_WORDS-1] = mem_init();
  logic [DAW-1:0] idx;

  assign idx     = DAW'(word_addr % 30'(DMEM_WORDS));
  assign rdata_c = mem[idx];

  // Store port.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end
endmodule

module cpu #(
  parameter int unsigned IMEM_WORDS = 64,
  parameter int unsigned DMEM_WORDS = 64
) (
  input logic clk,
  input logic rst
);
  localparam logic [6:0]  OP_LOAD   = 7'b0000011;
  localparam logic [6:0]  OP_STORE  = 7'b0100011;
  localparam logic [6:0]  OP_REG    = 7'b0110011;
  localparam logic [6:0]  OP_IMM    = 7'b0010011;
  localparam logic [6:0]  OP_BRANCH = 7'b1100011;
  localparam logic [6:0]  OP_JAL    = 7'b1101111;
  localparam logic [6:0]  OP_LUI    = 7'b0110111;
  localparam logic [6:0]  OP_AUIPC  = 7'b0010111;
  localparam logic [31:0] NOP       = 32'h00000013;

  // Instruction encoders for the ROM image; branch/jump offsets are passed pre-shifted (bit 0 dropped).
  function automatic logic [31:0] enc_i(input logic [11:0] imm, input logic [4:0] rs1,
                                        input logic [2:0] f3, input logic [4:0] rd,
                                        input logic [6:0] op);
    return {imm, rs1, f3, rd, op};
  endfunction

  function automatic logic [31:0] enc_lw(input logic [4:0] rd, input logic [11:0] imm);
    return enc_i(imm, 5'd0, 3'b010, rd, OP_LOAD);
  endfunction

  function automatic logic [31:0] enc_sw(input logic [4:0] rs2, input logic [11:0] imm);
    return {imm[11:5], rs2, 5'd0, 3'b010, imm[4:0], OP_STORE};
  endfunction

  function automatic logic [31:0] enc_r(input logic [4:0] rd, input logic [4:0] rs1,
                                        input logic [4:0] rs2, input logic [2:0] f3);
    return {7'b0000000, rs2, rs1, f3, rd, OP_REG};
  endfunction

  function automatic logic [31:0] enc_beq(input logic [4:0] rs1, input logic [4:0] rs2,
                                          input logic [12:1] off);
    return {off[12], off[10:5], rs2, rs1, 3'b000, off[4:1], off[11], OP_BRANCH};
  endfunction

  function automatic logic [31:0] enc_jal(input logic [4:0] rd, input logic [20:1] off);
    return {off[20], off[10:1], off[11], off[19:12], rd, OP_JAL};
  endfunction

  // Program image indexed by word; unlisted words are NOP.
  function automatic logic [31:0] rom_word(input logic [29:0] idx);
    case (idx)
      30'd0:   return enc_lw(5'd18, 12'd12);
      30'd1:   return enc_sw(5'd18, 12'd16);
      30'd2:   return enc_lw(5'd17, 12'd20);
      30'd3:   return enc_r(5'd19, 5'd18, 5'd17, 3'b000);
      30'd4:   return enc_r(5'd21, 5'd18, 5'd19, 3'b111);
      30'd5:   return enc_lw(5'd5, 12'd24);
      30'd6:   return enc_lw(5'd6, 12'd28);
      30'd7:   return enc_r(5'd7, 5'd5, 5'd6, 3'b110);
      30'd9:   return enc_beq(5'd6, 5'd7, 12'd6);
      30'd10:  return enc_lw(5'd22, 12'd8);
      30'd11:  return enc_beq(5'd18, 5'd22, 12'd8);
      30'd14:  return enc_beq(5'd0, 5'd0, 12'd6);
      30'd15:  return enc_lw(5'd22, 12'd0);
      30'd16:  return enc_beq(5'd22, 5'd22, 12'hFFC);
      30'd18:  return enc_jal(5'd1, 20'd6);
      30'd20:  return enc_jal(5'd1, 20'd6);
      30'd21:  return enc_jal(5'd1, 20'hFFFFE);
      30'd23:  return enc_lw(5'd7, 12'd12);
      30'd25:  return enc_lw(5'd18, 12'd0);
      30'd26:  return enc_i(12'h0BC, 5'd18, 3'b000, 5'd23, OP_IMM);
      30'd28:  return {20'h12345, 5'd5, OP_AUIPC};
      30'd29:  return {20'hABCDE, 5'd5, OP_LUI};
      default: return NOP;
    endcase
  endfunction

  logic [31:0] pc;
  logic [31:0] next_pc;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [4:0]  rd;
  logic [4:0]  rs1;
  logic [4:0]  rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm_i;
  logic [31:0] imm_s;
  logic [31:0] imm_b;
  logic [31:0] imm_j;
`ifdef CPU_UPPER_IMM_EN
  logic [31:0] imm_u;
`endif
  logic [31:0] rs1_val;
  logic [31:0] rs2_val;
  logic [29:0] mem_word;
  logic [31:0] mem_rdata;
  logic        mem_we;
  logic        reg_we;
  logic [31:0] reg_wdata;

  assign instr  = rom_word(pc[31:2] % 30'(IMEM_WORDS));
  assign opcode = instr[6:0];
  assign rd     = instr[11:7];
  assign funct3 = instr[14:12];
  assign rs1    = instr[19:15];
  assign rs2    = instr[24:20];
  assign funct7 = instr[31:25];
  assign imm_i  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_j  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
`ifdef CPU_UPPER_IMM_EN
  assign imm_u  = {instr[31:12], 12'h000};
`endif

  // Load/store effective word address; byte offset bits are dropped.
  assign mem_word = 30'((rs1_val + ((opcode == OP_STORE) ? imm_s : imm_i)) >> 2);

  cpu_regfile regfile_u (
    .clk      (clk),
    .rst      (rst),
    .we       (reg_we),
    .waddr    (rd),
    .wdata    (reg_wdata),
    .raddr1   (rs1),
    .raddr2   (rs2),
    .rdata1_c (rs1_val),
    .rdata2_c (rs2_val)
  );

  cpu_dmem #(.DMEM_WORDS(DMEM_WORDS)) dmemory (
    .clk       (clk),
    .we        (mem_we && !rst),
    .word_addr (mem_word),
    .wdata     (rs2_val),
    .rdata_c   (mem_rdata)
  );

  // Decode/execute: unknown opcodes and functs fall through to the pc+4, no-write defaults.
  always_comb begin
    next_pc   = pc + 32'd4;
    reg_we    = 1'b0;
    reg_wdata = 32'd0;
    mem_we    = 1'b0;
    case (opcode)
      OP_LOAD: begin
        if (funct3 == 3'b010) begin
          reg_we    = 1'b1;
          reg_wdata = mem_rdata;
        end
      end
      OP_STORE: begin
        if (funct3 == 3'b010) mem_we = 1'b1;
      end
      OP_REG: begin
        if (funct7 == 7'b0000000) begin
          case (funct3)
            3'b000: begin reg_we = 1'b1; reg_wdata = rs1_val + rs2_val; end
            3'b111: begin reg_we = 1'b1; reg_wdata = rs1_val & rs2_val; end
            3'b110: begin reg_we = 1'b1; reg_wdata = rs1_val | rs2_val; end
            default: ;
          endcase
        end
      end
      OP_IMM: begin
        if (funct3 == 3'b000) begin
          reg_we    = 1'b1;
          reg_wdata = rs1_val + imm_i;
        end
      end
      OP_BRANCH: begin
        if ((funct3 == 3'b000) && (rs1_val == rs2_val)) next_pc = pc + imm_b;
      end
      OP_JAL: begin
        reg_we    = 1'b1;
        reg_wdata = pc + 32'd4;
        next_pc   = pc + imm_j;
      end
`ifdef CPU_UPPER_IMM_EN
      OP_LUI: begin
        reg_we    = 1'b1;
        reg_wdata = imm_u;
      end
      OP_AUIPC: begin
        reg_we    = 1'b1;
        reg_wdata = pc + imm_u;
      end
`endif
      default: ;
    endcase
  end

  // Program counter; reset restarts fetch at address 0.
  always_ff @(posedge clk) begin
    if (rst) pc <= 32'd0;
    else     pc <= next_pc;
  end
endmodule

// File: tb/tb_cpu.sv
// Scoreboard bench for cpu: expectations are queued up front with the edge they apply to,
// and a negedge monitor pops and compares them against pc, registers and data RAM.
module tb_cpu;
  logic clk = 1'b0;
  logic rst = 1'b1;

  cpu dut (
    .clk (clk),
    .rst (rst)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          at;
    int          kind;   // 0 = pc, 1 = register, 2 = data RAM word
    int          idx;
    logic [31:0] val;
    string       name;
  } exp_t;

  exp_t sb[$];
  int   edge_n = 0;
  int   total  = 0;
  int   bad    = 0;

  localparam int B = 8;  // edge of the mid-program reset; instruction k retires at edge B+k

  always @(posedge clk) edge_n <= edge_n + 1;

  task automatic push(input int at, input int kind, input int idx, input logic [31:0] val,
                      input string name);
    exp_t e;
    e.at = at; e.kind = kind; e.idx = idx; e.val = val; e.name = name;
    sb.push_back(e);
  endtask

  // Monitor: compare every expectation that falls due on the edge just completed.
  always @(negedge clk) begin
    while (sb.size() > 0 && sb[0].at <= edge_n) begin
      exp_t        e;
      logic [31:0] act;
      e = sb.pop_front();
      case (e.kind)
        0:       act = dut.pc;
        1:       act = dut.regfile_u.registers[e.idx];
        default: act = dut.dmemory.mem[e.idx];
      endcase
      total++;
      if (e.at != edge_n) begin
        bad++;
        $display("FAIL %s: due at edge %0d, checked at edge %0d", e.name, e.at, edge_n);
      end else if (act !== e.val) begin
        bad++;
        $display("FAIL %s @edge %0d: got %h want %h", e.name, edge_n, act, e.val);
      end
    end
  end

  task automatic wait_edge(input int n);
    while (edge_n < n) @(negedge clk);
  endtask

  initial begin
    // Power-on reset over edges 1..2.
    push(2, 0, 0,  32'h0,        "reset_pc");
    push(2, 1, 18, 32'h0,        "reset_x18");
    push(2, 2, 4,  32'hF2F2F2F2, "preload_mem4");
    push(2, 2, 7,  32'h7F4FD46A, "preload_mem7");
    // First run, interrupted after five instructions.
    push(3, 1, 18, 32'hABCDEF11, "run1_lw_x18");
    push(3, 2, 4,  32'hF2F2F2F2, "run1_mem4_before_sw");
    push(4, 2, 4,  32'hABCDEF11, "run1_sw_mem4");
    push(6, 1, 19, 32'hBE024589, "run1_add_x19");
    push(7, 1, 21, 32'hAA004501, "run1_and_x21");
    // Single-edge reset at edge B.
    push(B, 0, 0,  32'h0,        "rst_pc");
    push(B, 1, 19, 32'h0,        "rst_x19");
    push(B, 1, 21, 32'h0,        "rst_x21");
    push(B, 2, 4,  32'hABCDEF11, "rst_mem4_kept");
    // Full program from 0x00.
    push(B+1,  1, 18, 32'hABCDEF11, "lw_x18");
    push(B+1,  0, 0,  32'h04,       "pc_after_1");
    push(B+8,  1, 17, 32'h12345678, "lw_x17");
    push(B+8,  1, 19, 32'hBE024589, "add_x19");
    push(B+8,  1, 21, 32'hAA004501, "and_x21");
    push(B+8,  1, 5,  32'h125F552D, "lw_x5");
    push(B+8,  1, 6,  32'h7F4FD46A, "lw_x6");
    push(B+8,  1, 7,  32'h7F5FD56F, "or_x7");
    push(B+9,  0, 0,  32'h24,       "pc_after_nop");
    push(B+10, 0, 0,  32'h28,       "beq_not_taken");
    push(B+11, 1, 22, 32'hABCDEF11, "lw_x22_a");
    push(B+12, 0, 0,  32'h3C,       "beq_taken_fwd");
    push(B+13, 1, 22, 32'hAEAEAEAE, "lw_x22_b");
    push(B+14, 0, 0,  32'h38,       "beq_taken_back");
    push(B+15, 0, 0,  32'h44,       "beq_x0_x0");
    push(B+16, 0, 0,  32'h48,       "pc_after_nop2");
    push(B+17, 0, 0,  32'h54,       "jal1_pc");
    push(B+17, 1, 1,  32'h4C,       "jal1_link");
    push(B+18, 0, 0,  32'h50,       "jal_back_pc");
    push(B+18, 1, 1,  32'h58,       "jal_back_link");
    push(B+19, 0, 0,  32'h5C,       "jal3_pc");
    push(B+19, 1, 1,  32'h54,       "jal3_link");
    push(B+20, 1, 7,  32'hABCDEF11, "lw_x7");
    push(B+21, 0, 0,  32'h64,       "pc_after_nop3");
    push(B+22, 1, 18, 32'hAEAEAEAE, "lw_x18_b");
    push(B+23, 1, 23, 32'hAEAEAF6A, "addi_x23");
`ifdef CPU_UPPER_IMM_EN
    push(B+25, 1, 5,  32'h12345070, "auipc_x5");
    push(B+26, 1, 5,  32'hABCDE000, "lui_x5");
`else
    push(B+25, 1, 5,  32'h125F552D, "auipc_nop_x5");
    push(B+26, 1, 5,  32'h125F552D, "lui_nop_x5");
`endif
    push(B+26, 0, 0,  32'h78,       "pc_after_upper");
    push(B+60, 0, 0,  32'h100,      "pc_rom_end");
    push(B+60, 1, 18, 32'hAEAEAEAE, "x18_before_wrap");
    push(B+60, 1, 0,  32'h0,        "x0_zero");
    push(B+61, 1, 18, 32'hABCDEF11, "rom_wrap_lw_x18");
    push(B+61, 0, 0,  32'h104,      "pc_no_wrap");

    wait_edge(2);
    rst = 1'b0;
    wait_edge(B-1);
    rst = 1'b1;
    wait_edge(B);
    rst = 1'b0;
    wait_edge(B+62);
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule
